// File: rtl/gnet_frame_tx_if.sv
// Payload, request-frame, echo and status signals of the gnet frame transmitter.
// The master modport is the transmitter; the slave modport is its environment.
interface gnet_frame_tx_if;
    logic [1:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] A_b_i;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] A_b_o;
    logic       echo_valid;
    logic [7:0] err_cnt;
    logic [7:0] to_cnt;
    logic       busy;

    modport master (
        input  pl_data, pl_valid, tx_ready, A_b_o, echo_valid,
        output pl_ready, A_b_i, tx_valid, err_cnt, to_cnt, busy
    );

    modport slave (
        output pl_data, pl_valid, tx_ready, A_b_o, echo_valid,
        input  pl_ready, A_b_i, tx_valid, err_cnt, to_cnt, busy
    );
endinterface

// File: rtl/gnet_frame_tx.sv
// Frame transmitter: queues 2-bit payloads, sends {2'b10, payload, TRAILER}
// request frames and checks the echoed frame, counting mismatches and timeouts.
module gnet_frame_tx #(
    parameter int         DEPTH   = 4,
    parameter int         TIMEOUT = 15,
    parameter logic [3:0] TRAILER = 4'b0000
) (
    input  logic            clk,
    input  logic            rst,
    gnet_frame_tx_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ECHO} state_e;

    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          fifo_full, fifo_empty, push, pop;

    state_e     state_q, state_d;
    logic [1:0] payload_q, payload_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] err_q, err_d;
    logic [7:0] to_q, to_d;
    logic       tx_valid;
    logic [7:0] frame;
    logic       echo_ok;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = bus.pl_valid && bus.pl_ready;
    assign pop        = (state_q == IDLE) && !fifo_empty;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign bus.pl_ready = !fifo_full && !rst;

    // NOTE: payload storage has no reset; the pointers and count alone define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.pl_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            payload_q <= '0;
            timer_q   <= '0;
            err_q     <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            to_q      <= to_d;
        end
    end

    // Low two echo bits are don't-care.
    assign echo_ok = ((bus.A_b_o & 8'hFC) == {2'b11, payload_q, 4'b0000});

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        payload_d = payload_q;
        timer_d   = timer_q;
        err_d     = err_q;
        to_d      = to_q;
        tx_valid  = 1'b0;
        frame     = 8'h00;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    payload_d = mem_q[rd_ptr_q];
                    state_d   = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                frame    = {2'b10, payload_q, TRAILER};
                if (bus.tx_ready) begin
                    timer_d = '0;
                    state_d = WAIT_ECHO;
                end
            end
            WAIT_ECHO: begin
                timer_d = timer_q + 8'd1;
                // An echo on the deadline cycle takes priority over the timeout.
                if (bus.echo_valid) begin
                    if (!echo_ok && err_q != 8'hFF) err_d = err_q + 8'd1;
                    state_d = IDLE;
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    if (to_q != 8'hFF) to_d = to_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx_valid = tx_valid;
    assign bus.A_b_i    = frame;
    assign bus.err_cnt  = err_q;
    assign bus.to_cnt   = to_q;
    assign bus.busy     = (state_q != IDLE) || !fifo_empty;
endmodule
